// File: rtl/muller_c_pkg.sv
// Shared types and widths for the Muller C-element stimulus/check driver.
package muller_c_pkg;

    localparam int LAT_W  = 8;
    localparam int SKEW_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RISE_A,
        WAIT_HI,
        FALL_A,
        WAIT_LO,
        DONE,
        ERR
    } drv_state_t;

endpackage

// File: rtl/muller_c_sync2.sv
// Two-flop synchronizer with synchronous active-high reset, for bringing
// asynchronous handshake signals into a clock domain.
module muller_c_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so r_sync takes
    // the old r_meta, giving two genuine flop stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/muller_c_driver.sv
// Four-phase handshake driver for a Muller C-element: programmable skew
// between a and b, hold-violation and timeout detection, latency capture.
module muller_c_driver
    import muller_c_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    n_hs_i,
    input  logic [SKEW_W-1:0]   skew_i,
    input  logic                c_i,
    output logic                a_o,
    output logic                b_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CNT_W-1:0]    hs_cnt_o,
    output logic [LAT_W-1:0]    last_lat_o
);

    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT - 1);

    drv_state_t          r_state;
    logic                r_a;
    logic                r_b;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [CNT_W-1:0]    r_hs_cnt;
    logic [CNT_W-1:0]    r_n_hs;
    logic [SKEW_W-1:0]   r_skew;
    logic [SKEW_W-1:0]   r_skew_cnt;
    logic [LAT_W-1:0]    r_lat;
    logic [LAT_W-1:0]    r_last_lat;

    logic                w_c_s;
    logic [CNT_W-1:0]    w_hs_next;

    muller_c_sync2 u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (c_i),
        .o_q   (w_c_s)
    );

    assign w_hs_next = r_hs_cnt + CNT_W'(1);

    // Outputs are registered and updated on the transition into each state,
    // so busy/done/err line up with the state they describe.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_hs_cnt   <= '0;
            r_n_hs     <= '0;
            r_skew     <= '0;
            r_skew_cnt <= '0;
            r_lat      <= '0;
            r_last_lat <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_n_hs   <= n_hs_i;
                        r_skew   <= skew_i;
                        r_hs_cnt <= '0;
                        if (n_hs_i == '0) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_a        <= 1'b1;
                            r_busy     <= 1'b1;
                            r_skew_cnt <= skew_i;
                            r_state    <= RISE_A;
                        end
                    end
                end
                RISE_A: begin
                    if (w_c_s) begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else if (r_skew_cnt == '0) begin
                        r_b     <= 1'b1;
                        r_lat   <= '0;
                        r_state <= WAIT_HI;
                    end else begin
                        r_skew_cnt <= r_skew_cnt - SKEW_W'(1);
                    end
                end
                WAIT_HI: begin
                    if (w_c_s) begin
                        r_last_lat <= r_lat;
                        r_a        <= 1'b0;
                        r_skew_cnt <= r_skew;
                        r_state    <= FALL_A;
                    end else if (r_lat == LAT_LIMIT) begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                FALL_A: begin
                    if (!w_c_s) begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else if (r_skew_cnt == '0) begin
                        r_b     <= 1'b0;
                        r_lat   <= '0;
                        r_state <= WAIT_LO;
                    end else begin
                        r_skew_cnt <= r_skew_cnt - SKEW_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!w_c_s) begin
                        r_hs_cnt <= w_hs_next;
                        if (w_hs_next == r_n_hs) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_a        <= 1'b1;
                            r_skew_cnt <= r_skew;
                            r_state    <= RISE_A;
                        end
                    end else if (r_lat == LAT_LIMIT) begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_o        = r_a;
    assign b_o        = r_b;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign hs_cnt_o   = r_hs_cnt;
    assign last_lat_o = r_last_lat;

endmodule

// File: tb/tb_muller_c_driver.sv
// Directed self-checking bench for muller_c_driver with behavioural
// C-element, OR-gate, stuck-low and random c_i sources.
module tb_muller_c_driver;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              start_i;
    logic [CNT_W-1:0]  n_hs_i;
    logic [3:0]        skew_i;
    logic              c_i = 1'b0;
    logic              a_o;
    logic              b_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [CNT_W-1:0]  hs_cnt_o;
    logic [7:0]        last_lat_o;

    typedef enum {M_RAND, M_IDEAL, M_OR, M_LOW} c_mode_t;
    c_mode_t mode   = M_RAND;
    logic    c_rand = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    muller_c_driver #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start_i    (start_i),
        .n_hs_i     (n_hs_i),
        .skew_i     (skew_i),
        .c_i        (c_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .hs_cnt_o   (hs_cnt_o),
        .last_lat_o (last_lat_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Zero-delay element models; the ideal C-element holds its value
    // whenever a and b disagree.
    always @(a_o, b_o, mode, c_rand) begin
        case (mode)
            M_IDEAL: c_i = (a_o & b_o) | (c_i & (a_o | b_o));
            M_OR:    c_i = a_o | b_o;
            M_LOW:   c_i = 1'b0;
            default: c_i = c_rand;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'b000, a_o, b_o, busy_o, done_o, err_o, hs_cnt_o, last_lat_o};
    endfunction

    int  a_rises, b_rises, dones, done_at, b_at;
    logic prev_a, prev_b, c_early;

    initial begin
        wb_rst_i = 1'b1;
        start_i  = 1'b0;
        n_hs_i   = '0;
        skew_i   = '0;

        // Reset with random inputs, then release with start held low.
        for (int i = 0; i < 3; i++) begin
            start_i = 1'($urandom_range(0, 1));
            n_hs_i  = 16'($urandom);
            skew_i  = 4'($urandom);
            c_rand  = 1'($urandom);
            tick();
        end
        check("reset_outputs", outs(), 32'h0);
        wb_rst_i = 1'b0;
        start_i  = 1'b0;
        mode     = M_IDEAL;
        repeat (3) tick();
        check("idle_after_release", outs(), 32'h0);

        // Ideal element, three handshakes, no skew.
        n_hs_i  = 16'd3;
        skew_i  = 4'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_hs_i  = 16'd0;
        check("ideal3_start_abbusy", {29'b0, a_o, b_o, busy_o}, 32'b101);
        a_rises = 1; b_rises = 0; dones = 0; done_at = -1;
        prev_a = 1'b1; prev_b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (a_o && !prev_a) a_rises++;
            if (b_o && !prev_b) b_rises++;
            if (done_o) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            prev_a = a_o;
            prev_b = b_o;
        end
        check("ideal3_a_rises", a_rises, 3);
        check("ideal3_b_rises", b_rises, 3);
        check("ideal3_done_pulses", dones, 1);
        check("ideal3_done_cycle", done_at, 24);
        check("ideal3_hs_cnt", hs_cnt_o, 3);
        check("ideal3_last_lat", last_lat_o, 2);
        check("ideal3_err_busy", {err_o, busy_o}, 2'b00);

        // Ideal element, one handshake, skew 5.
        n_hs_i  = 16'd1;
        skew_i  = 4'd5;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("skew5_a_rise", {a_o, b_o}, 2'b10);
        b_at = -1; dones = 0; done_at = -1; c_early = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (b_at < 0 && !b_o && c_i) c_early = 1'b1;
            if (b_at < 0 && b_o) b_at = k;
            if (done_o) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
        end
        check("skew5_b_delay", b_at, 6);
        check("skew5_c_quiet", c_early, 0);
        check("skew5_done_pulses", dones, 1);
        check("skew5_done_cycle", done_at, 18);
        check("skew5_err", err_o, 0);
        check("skew5_hs_lat", {hs_cnt_o, last_lat_o}, {16'd1, 8'd2});

        // OR gate in place of the C-element: hold violation in RISE_A.
        mode    = M_OR;
        n_hs_i  = 16'd2;
        skew_i  = 4'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("or_pre_err", {a_o, b_o, busy_o, err_o}, 4'b1010);
        tick();
        check("or_err_entry", {a_o, b_o, busy_o, err_o}, 4'b0001);
        start_i = 1'b1;
        n_hs_i  = 16'd1;
        skew_i  = 4'd0;
        dones   = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_o) dones++;
        end
        start_i = 1'b0;
        tick();
        check("or_start_ignored", {a_o, b_o, busy_o, err_o}, 4'b0001);
        check("or_no_done", dones, 0);

        // Stuck-low element: timeout in WAIT_HI.
        wb_rst_i = 1'b1;
        mode     = M_LOW;
        tick();
        tick();
        wb_rst_i = 1'b0;
        check("low_reset_clears", outs(), 32'h0);
        n_hs_i  = 16'd1;
        skew_i  = 4'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (20) tick();
        check("low_before_timeout", {a_o, b_o, busy_o, err_o}, 4'b1110);
        tick();
        check("low_timeout_err", {a_o, b_o, busy_o, err_o}, 4'b0001);
        check("low_hs_cnt", hs_cnt_o, 0);

        // Reset in the middle of WAIT_HI, then a zero-handshake run.
        wb_rst_i = 1'b1;
        mode     = M_IDEAL;
        tick();
        tick();
        wb_rst_i = 1'b0;
        n_hs_i   = 16'd2;
        skew_i   = 4'd0;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("mid_wait_hi_state", {a_o, b_o, busy_o}, 3'b111);
        wb_rst_i = 1'b1;
        tick();
        check("mid_reset_outputs", outs(), 32'h0);
        tick();
        check("mid_reset_no_done", done_o, 0);
        wb_rst_i = 1'b0;
        n_hs_i   = 16'd0;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        check("zero_hs_done", outs(), {27'b0, 5'b00010} << 24);
        tick();
        check("zero_hs_idle", outs(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
